// File: rtl/fp_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_cmp_pkg
// Brief    : Shared constants, types and helpers for the vector FP compare unit.
// Revision : 1.0 - initial release
// ============================================================================
package fp_cmp_pkg;

  // Operation encodings on iFunct (3, 6 and 7 are illegal)
  localparam logic [2:0] FN_FLE  = 3'd0;
  localparam logic [2:0] FN_FLT  = 3'd1;
  localparam logic [2:0] FN_FEQ  = 3'd2;
  localparam logic [2:0] FN_FMIN = 3'd4;
  localparam logic [2:0] FN_FMAX = 3'd5;

  // Position of the invalid-operation flag in {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set
  localparam logic [31:0] CNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] CNAN64 = 64'h7FF8_0000_0000_0000;

  // Per-lane pre-classification captured at the S1 boundary
  typedef struct packed {
    logic a_snan;
    logic a_qnan;
    logic a_zero;
    logic a_sign;
    logic b_snan;
    logic b_qnan;
    logic b_zero;
    logic b_sign;
    logic mag_lt;   // |A| < |B|
    logic mag_eq;   // |A| == |B|
  } lane_cls_t;

  // Exponent field width for a legal element width
  function automatic int unsigned exp_width(input int unsigned flen);
    return (flen == 64) ? 11 : 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lane_cmp.sv
`default_nettype none
// ============================================================================
// Module   : fp_lane_cmp
// Brief    : Single-lane FP classify (pre-register) and compare/select
//            (post-register) logic. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module fp_lane_cmp
  import fp_cmp_pkg::*;
#(
  parameter int unsigned FLEN = 32
) (
  // classification half, fed by raw operands
  input  logic [FLEN-1:0] i_a_raw,
  input  logic [FLEN-1:0] i_b_raw,
  output lane_cls_t       o_cls,
  // decision half, fed by S1 registers
  input  lane_cls_t       i_cls,
  input  logic [FLEN-1:0] i_a,
  input  logic [FLEN-1:0] i_b,
  input  logic [2:0]      i_funct,
  input  logic            i_en,
  output logic [FLEN-1:0] o_result,
  output logic            o_nv
);

  localparam int unsigned c_EW = exp_width(FLEN);
  localparam int unsigned c_MW = FLEN - 1 - c_EW;
  localparam logic [63:0] c_CNAN_W = (FLEN == 64) ? CNAN64 : {32'h0, CNAN32};
  localparam logic [FLEN-1:0] c_CNAN = c_CNAN_W[FLEN-1:0];

  logic w_a_nan_raw, w_b_nan_raw;
  logic w_a_nan, w_b_nan, w_any_nan, w_any_snan;
  logic w_both_zero, w_eq, w_lt_ord, w_lt;

  // Classification: NaN when exponent saturated and mantissa non-zero;
  // mantissa MSB distinguishes quiet from signalling.
  assign w_a_nan_raw = (&i_a_raw[FLEN-2 -: c_EW]) & (|i_a_raw[c_MW-1:0]);
  assign w_b_nan_raw = (&i_b_raw[FLEN-2 -: c_EW]) & (|i_b_raw[c_MW-1:0]);

  assign o_cls.a_snan = w_a_nan_raw & ~i_a_raw[c_MW-1];
  assign o_cls.a_qnan = w_a_nan_raw &  i_a_raw[c_MW-1];
  assign o_cls.a_zero = ~|i_a_raw[FLEN-2:0];
  assign o_cls.a_sign = i_a_raw[FLEN-1];
  assign o_cls.b_snan = w_b_nan_raw & ~i_b_raw[c_MW-1];
  assign o_cls.b_qnan = w_b_nan_raw &  i_b_raw[c_MW-1];
  assign o_cls.b_zero = ~|i_b_raw[FLEN-2:0];
  assign o_cls.b_sign = i_b_raw[FLEN-1];
  assign o_cls.mag_lt = i_a_raw[FLEN-2:0] <  i_b_raw[FLEN-2:0];
  assign o_cls.mag_eq = i_a_raw[FLEN-2:0] == i_b_raw[FLEN-2:0];

  assign w_a_nan    = i_cls.a_snan | i_cls.a_qnan;
  assign w_b_nan    = i_cls.b_snan | i_cls.b_qnan;
  assign w_any_nan  = w_a_nan | w_b_nan;
  assign w_any_snan = i_cls.a_snan | i_cls.b_snan;

  // Total order with -0 < +0 (used by FMIN/FMAX); the compare ops then
  // mask out the signed-zero case so that +-0 compare equal.
  assign w_both_zero = i_cls.a_zero & i_cls.b_zero;
  assign w_eq        = w_both_zero | ((i_cls.a_sign == i_cls.b_sign) & i_cls.mag_eq);
  assign w_lt_ord    = (i_cls.a_sign != i_cls.b_sign) ? i_cls.a_sign :
                       (i_cls.a_sign ? ~(i_cls.mag_lt | i_cls.mag_eq) : i_cls.mag_lt);
  assign w_lt        = w_lt_ord & ~w_both_zero;

  // Per-operation result select and invalid flag; masked lanes and
  // illegal encodings produce zero with no flag.
  always_comb begin
    o_result = '0;
    o_nv     = 1'b0;
    if (i_en) begin
      case (i_funct)
        FN_FEQ: begin
          o_result = {{(FLEN-1){1'b0}}, w_eq & ~w_any_nan};
          o_nv     = w_any_snan;
        end
        FN_FLT: begin
          o_result = {{(FLEN-1){1'b0}}, w_lt & ~w_any_nan};
          o_nv     = w_any_nan;
        end
        FN_FLE: begin
          o_result = {{(FLEN-1){1'b0}}, (w_lt | w_eq) & ~w_any_nan};
          o_nv     = w_any_nan;
        end
        FN_FMIN, FN_FMAX: begin
          if (w_a_nan & w_b_nan) o_result = c_CNAN;
          else if (w_a_nan)      o_result = i_b;
          else if (w_b_nan)      o_result = i_a;
          else if (i_funct == FN_FMIN) o_result = w_lt_ord ? i_a : i_b;
          else                         o_result = w_lt_ord ? i_b : i_a;
          o_nv = w_any_snan;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_cmp_vec.sv
`default_nettype none
// ============================================================================
// Module   : fp_cmp_vec
// Brief    : Two-stage pipelined multi-lane FP compare / min-max unit with
//            lane masking, tag side-band and valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp_cmp_vec
  import fp_cmp_pkg::*;
#(
  parameter int unsigned FLEN      = 32,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TAG_W     = 6
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic [2:0]                iFunct,
  input  logic [NUM_LANES-1:0]      iMask,
  input  logic [NUM_LANES*FLEN-1:0] iData1,
  input  logic [NUM_LANES*FLEN-1:0] iData2,
  input  logic [TAG_W-1:0]          iTag,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [NUM_LANES*FLEN-1:0] oResult,
  output logic [4:0]                oFlags,
  output logic [TAG_W-1:0]          oTag
);

  // S1 state
  logic                        r1_valid;
  logic [2:0]                  r1_funct;
  logic [NUM_LANES-1:0]        r1_mask;
  logic [TAG_W-1:0]            r1_tag;
  logic [NUM_LANES*FLEN-1:0]   r1_a;
  logic [NUM_LANES*FLEN-1:0]   r1_b;
  lane_cls_t [NUM_LANES-1:0]   r1_cls;

  // S2 state
  logic                        r2_valid;
  logic [NUM_LANES*FLEN-1:0]   r2_result;
  logic [4:0]                  r2_flags;
  logic [TAG_W-1:0]            r2_tag;

  lane_cls_t [NUM_LANES-1:0]   w_cls;
  logic [NUM_LANES*FLEN-1:0]   w_res;
  logic [NUM_LANES-1:0]        w_nv;
  logic [4:0]                  w_flags;
  logic                        w_en1, w_en2;

  // A stage advances when it is empty or the stage after it advances
  assign w_en2  = ~r2_valid | iReady;
  assign w_en1  = ~r1_valid | w_en2;
  assign oReady = w_en1;

  assign oValid  = r2_valid;
  assign oResult = r2_result;
  assign oFlags  = r2_flags;
  assign oTag    = r2_tag;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      fp_lane_cmp #(.FLEN(FLEN)) u_lane (
        .i_a_raw  (iData1[gi*FLEN +: FLEN]),
        .i_b_raw  (iData2[gi*FLEN +: FLEN]),
        .o_cls    (w_cls[gi]),
        .i_cls    (r1_cls[gi]),
        .i_a      (r1_a[gi*FLEN +: FLEN]),
        .i_b      (r1_b[gi*FLEN +: FLEN]),
        .i_funct  (r1_funct),
        .i_en     (r1_mask[gi]),
        .o_result (w_res[gi*FLEN +: FLEN]),
        .o_nv     (w_nv[gi])
      );
    end
  endgenerate

  // Only NV can ever be raised; it is the OR over active lanes
  always_comb begin
    w_flags          = '0;
    w_flags[FLAG_NV] = |w_nv;
  end

  // S1: capture operands and lane classification on an accepted transfer
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r1_valid <= 1'b0;
      r1_funct <= '0;
      r1_mask  <= '0;
      r1_tag   <= '0;
      r1_a     <= '0;
      r1_b     <= '0;
      r1_cls   <= '0;
    end else if (w_en1) begin
      r1_valid <= iValid;
      if (iValid) begin
        r1_funct <= iFunct;
        r1_mask  <= iMask;
        r1_tag   <= iTag;
        r1_a     <= iData1;
        r1_b     <= iData2;
        r1_cls   <= w_cls;
      end
    end
  end

  // S2: register final result, flags and tag; held while stalled
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_flags  <= '0;
      r2_tag    <= '0;
    end else if (w_en2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_res;
        r2_flags  <= w_flags;
        r2_tag    <= r1_tag;
      end
    end
  end

endmodule
`default_nettype wire
